// File: rtl/ofm_pkg.sv
// Shared definitions for the output-feature-map tile buffer:
// bank state encoding, default geometry, and a counter-width helper.
package ofm_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY = 2'd0,
        BANK_FILL  = 2'd1,
        BANK_FULL  = 2'd2,
        BANK_DRAIN = 2'd3
    } bank_state_t;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_WR_LANES   = 5;
    localparam int unsigned DEF_RD_LANES   = 4;
    localparam int unsigned DEF_ROW_LEN    = 48;
    localparam int unsigned DEF_NUM_ROWS   = 40;

    // Bits needed to hold values 0..n-1, never less than 1.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if (((n - 1) >> i) != 0) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ofm_bank_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register holds its value while re is low.
//   clk   : clock
//   we    : write enable, waddr/wdata : write address/data
//   re    : read enable,  raddr/rdata : read address/registered data
module ofm_bank_ram
    import ofm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = clog2_min1(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/ofm_tile_buf.sv
// Ping-pong tile buffer: accepts column beats (WR_LANES consecutive rows of one
// column) and emits row-major beats (RD_LANES consecutive columns of one row).
//   clk, rst, clear           : clock, sync active-high reset, sync abort
//   wr_valid/wr_ready/wr_data : write beat handshake, MSB lane = first row
//   rd_valid/rd_ready/rd_data : read beat handshake, MSB lane = lowest column
//   rd_last                   : final read beat of a tile
//   tile_done                 : pulses while the last write beat of a tile is accepted
// Storage is split into WR_LANES x RD_LANES RAMs indexed by (row % WR_LANES,
// col % RD_LANES) so that both beat shapes touch each RAM at most once.
module ofm_tile_buf
    import ofm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned WR_LANES   = DEF_WR_LANES,
    parameter int unsigned RD_LANES   = DEF_RD_LANES,
    parameter int unsigned ROW_LEN    = DEF_ROW_LEN,
    parameter int unsigned NUM_ROWS   = DEF_NUM_ROWS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [DATA_WIDTH*WR_LANES-1:0] wr_data,
    output logic                           rd_valid,
    input  logic                           rd_ready,
    output logic [DATA_WIDTH*RD_LANES-1:0] rd_data,
    output logic                           tile_done,
    output logic                           rd_last
);

    localparam int unsigned CB_N       = ROW_LEN / RD_LANES;
    localparam int unsigned RG_N       = NUM_ROWS / WR_LANES;
    localparam int unsigned BANK_DEPTH = RG_N * CB_N;
    localparam int unsigned RAM_DEPTH  = 2 * BANK_DEPTH;
    localparam int unsigned CBW        = clog2_min1(CB_N);
    localparam int unsigned RGW        = clog2_min1(RG_N);
    localparam int unsigned KW         = clog2_min1(WR_LANES);
    localparam int unsigned JW         = clog2_min1(RD_LANES);
    localparam int unsigned AW         = clog2_min1(RAM_DEPTH);

    bank_state_t bank_st [2];
    bank_state_t bank_nx [2];
    logic        wr_ptr, wr_ptr_nx, rd_ptr, rd_ptr_nx, wr_ready_nx;

    // Write column = wr_cb*RD_LANES + wr_cj; row group = wr_rg.
    logic [JW-1:0]  wr_cj;
    logic [CBW-1:0] wr_cb;
    logic [RGW-1:0] wr_rg;
    // Read row = rd_rg*WR_LANES + rd_k; column beat = rd_cb.
    logic [CBW-1:0] rd_cb;
    logic [KW-1:0]  rd_k;
    logic [RGW-1:0] rd_rg;
    logic           rd_issued;

    // Stage 1 mirrors the RAM read register; stage 2 is rd_data.
    logic           s1_valid, s1_last;
    logic [KW-1:0]  s1_k;

    logic rst_any, wr_fire, wr_col_end, wr_tile_end;
    logic rd_done, adv_out, rd_bank_ready, issue, issue_last;
    logic [AW-1:0] waddr, raddr;
    logic [DATA_WIDTH-1:0] ram_q [WR_LANES][RD_LANES];
    logic [DATA_WIDTH*RD_LANES-1:0] rd_data_nx;

    assign rst_any     = rst | clear;
    assign wr_fire     = wr_valid & wr_ready & ~rst_any;
    assign wr_col_end  = (wr_cj == JW'(RD_LANES - 1)) && (wr_cb == CBW'(CB_N - 1));
    assign wr_tile_end = wr_fire && wr_col_end && (wr_rg == RGW'(RG_N - 1));
    assign tile_done   = wr_tile_end;

    assign rd_done       = rd_valid & rd_ready & rd_last & ~rst_any;
    assign adv_out       = ~rd_valid | rd_ready;
    assign rd_bank_ready = (bank_st[rd_ptr] == BANK_FULL) || (bank_st[rd_ptr] == BANK_DRAIN);
    assign issue         = rd_bank_ready & ~rd_issued & (~s1_valid | adv_out) & ~rst_any;
    assign issue_last    = (rd_rg == RGW'(RG_N - 1)) && (rd_k == KW'(WR_LANES - 1))
                           && (rd_cb == CBW'(CB_N - 1));

    assign waddr = AW'(BANK_DEPTH * 32'(wr_ptr) + CB_N * 32'(wr_rg) + 32'(wr_cb));
    assign raddr = AW'(BANK_DEPTH * 32'(rd_ptr) + CB_N * 32'(rd_rg) + 32'(rd_cb));

    // Bank state, pointer and wr_ready next-state logic.
    always_comb begin
        bank_nx[0] = bank_st[0];
        bank_nx[1] = bank_st[1];
        wr_ptr_nx  = wr_ptr;
        rd_ptr_nx  = rd_ptr;
        if (wr_fire) begin
            if (wr_tile_end) begin
                bank_nx[wr_ptr] = BANK_FULL;
                wr_ptr_nx       = ~wr_ptr;
            end else if (bank_st[wr_ptr] == BANK_EMPTY) begin
                bank_nx[wr_ptr] = BANK_FILL;
            end
        end
        if (issue && (bank_st[rd_ptr] == BANK_FULL)) bank_nx[rd_ptr] = BANK_DRAIN;
        if (rd_done) begin
            bank_nx[rd_ptr] = BANK_EMPTY;
            rd_ptr_nx       = ~rd_ptr;
        end
        // Registered wr_ready tracks whichever bank the write pointer lands on.
        wr_ready_nx = (bank_nx[wr_ptr_nx] == BANK_EMPTY) || (bank_nx[wr_ptr_nx] == BANK_FILL);
    end

    // Output lane mux: pick the RAM row lane captured with this read.
    always_comb begin
        rd_data_nx = '0;
        for (int unsigned j = 0; j < RD_LANES; j++) begin
            rd_data_nx[(RD_LANES-1-j)*DATA_WIDTH +: DATA_WIDTH] = ram_q[s1_k][j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_any) begin
            bank_st[0] <= BANK_EMPTY;
            bank_st[1] <= BANK_EMPTY;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            wr_ready   <= 1'b0;
            wr_cj      <= '0;
            wr_cb      <= '0;
            wr_rg      <= '0;
            rd_cb      <= '0;
            rd_k       <= '0;
            rd_rg      <= '0;
            rd_issued  <= 1'b0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_k       <= '0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            rd_data    <= '0;
        end else begin
            bank_st[0] <= bank_nx[0];
            bank_st[1] <= bank_nx[1];
            wr_ptr     <= wr_ptr_nx;
            rd_ptr     <= rd_ptr_nx;
            wr_ready   <= wr_ready_nx;

            if (wr_fire) begin
                if (wr_cj == JW'(RD_LANES - 1)) begin
                    wr_cj <= '0;
                    if (wr_cb == CBW'(CB_N - 1)) begin
                        wr_cb <= '0;
                        wr_rg <= (wr_rg == RGW'(RG_N - 1)) ? '0 : wr_rg + RGW'(1);
                    end else begin
                        wr_cb <= wr_cb + CBW'(1);
                    end
                end else begin
                    wr_cj <= wr_cj + JW'(1);
                end
            end

            if (issue) begin
                s1_valid <= 1'b1;
                s1_k     <= rd_k;
                s1_last  <= issue_last;
                if (issue_last) rd_issued <= 1'b1;
                if (rd_cb == CBW'(CB_N - 1)) begin
                    rd_cb <= '0;
                    if (rd_k == KW'(WR_LANES - 1)) begin
                        rd_k  <= '0;
                        rd_rg <= (rd_rg == RGW'(RG_N - 1)) ? '0 : rd_rg + RGW'(1);
                    end else begin
                        rd_k <= rd_k + KW'(1);
                    end
                end else begin
                    rd_cb <= rd_cb + CBW'(1);
                end
            end else if (adv_out) begin
                s1_valid <= 1'b0;
            end

            if (rd_done) rd_issued <= 1'b0;

            // rd_data only moves when the output slot is free or being consumed.
            if (adv_out) begin
                rd_valid <= s1_valid;
                rd_last  <= s1_valid & s1_last;
                if (s1_valid) rd_data <= rd_data_nx;
            end
        end
    end

    for (genvar k = 0; k < WR_LANES; k++) begin : g_row_lane
        for (genvar j = 0; j < RD_LANES; j++) begin : g_col_lane
            ofm_bank_ram #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (RAM_DEPTH),
                .ADDR_WIDTH (AW)
            ) u_ram (
                .clk   (clk),
                .we    (wr_fire && (wr_cj == JW'(j))),
                .waddr (waddr),
                .wdata (wr_data[(WR_LANES-1-k)*DATA_WIDTH +: DATA_WIDTH]),
                .re    (issue),
                .raddr (raddr),
                .rdata (ram_q[k][j])
            );
        end
    end

endmodule

// File: doc/ofm_tile_buf.md
OFM_TILE_BUF -- requirements
Module: ofm_tile_buf

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per pixel.
REQ-002 Parameter WR_LANES, default 5: pixels per write beat, one pixel per consecutive row in a single column.
REQ-003 Parameter RD_LANES, default 4: pixels per read beat, consecutive columns of one row.
REQ-004 Parameter ROW_LEN, default 48: columns per tile row; ROW_LEN % RD_LANES == 0 is required.
REQ-005 Parameter NUM_ROWS, default 40: rows per tile; NUM_ROWS % WR_LANES == 0 is required.
REQ-006 Port clk, input, 1: sole clock; all logic runs on its rising edge.
REQ-007 Port rst, input, 1: reset, synchronous and active-high.
REQ-008 Port clear, input, 1: synchronous abort; same effect as rst.
REQ-009 Port wr_valid, input, 1: write beat offered.
REQ-010 Port wr_ready, output, 1: write beat accepted when wr_valid && wr_ready.
REQ-011 Port wr_data, input, DATA_WIDTH*WR_LANES: MSB lane goes to the group's first row, LSB lane to its last row.
REQ-012 Port rd_valid, output, 1: rd_data holds a valid beat.
REQ-013 Port rd_ready, input, 1: beat consumed when rd_valid && rd_ready.
REQ-014 Port rd_data, output, DATA_WIDTH*RD_LANES: MSB lane holds the lowest column.
REQ-015 Port tile_done, output, 1: one-cycle pulse on the cycle the last write beat of a tile is accepted.
REQ-016 Port rd_last, output, 1: qualifies the final read beat of a tile.

Function
REQ-017 Two tile banks (ping-pong); each bank is in state EMPTY, FILL, FULL or DRAIN.
REQ-018 Write side: a column counter (0..ROW_LEN-1) and a row-group counter (0..NUM_ROWS/WR_LANES-1) address the write bank.
REQ-019 On an accepted beat, pixels are stored at (row_group*WR_LANES+k, col) for k=0..WR_LANES-1, and col increments.
REQ-020 At col==ROW_LEN-1, col wraps to 0 and the row-group counter increments.
REQ-021 On the last beat of the last row group, the write bank goes FILL->FULL, tile_done pulses, and the write pointer toggles to the other bank.
REQ-022 wr_ready = 1 iff the write bank is EMPTY or FILL; the first accepted beat moves the bank EMPTY->FILL.
REQ-023 Read side drains the read bank in row-major order, RD_LANES columns per beat, ROW_LEN/RD_LANES beats per row, rows 0..NUM_ROWS-1.
REQ-024 Reading starts only from a FULL bank (FULL->DRAIN); a partially filled bank is never read.
REQ-025 rd_data is registered; first rd_valid occurs no earlier than 2 cycles after the bank becomes FULL.
REQ-026 With rd_ready held high, read throughput is one beat per cycle with no bubbles inside a tile.
REQ-027 rd_valid=0 holds rd_data unchanged; rd_valid=1 && rd_ready=0 holds rd_data and rd_last stable until consumed.
REQ-028 On consumption of the rd_last beat, the bank goes DRAIN->EMPTY and the read pointer toggles.
REQ-029 Simultaneous fill-complete on one bank and drain-complete on the other in the same cycle are both honoured.
REQ-030 In that case, the write side's next wr_ready follows the state of the newly selected bank.
REQ-031 Both banks FULL/DRAIN: wr_ready=0 and no write is lost.
REQ-032 Both banks EMPTY: rd_valid=0.
REQ-033 The write side and read side operate concurrently on different banks; the same bank is never written and read in the same tile.

Reset
REQ-034 On rst or clear: both banks EMPTY, all counters 0, both pointers at bank 0.
REQ-035 On rst or clear: wr_ready=0 in the reset cycle and 1 from the next cycle.
REQ-036 On rst or clear: rd_valid=0, rd_last=0, tile_done=0, rd_data=0.
REQ-037 On rst or clear: memory contents are not cleared, and a tile in progress is discarded.
REQ-038 rst/clear overrides any handshake in the same cycle; no beat is accepted in that cycle.

Structure
REQ-039 A shared package ofm_pkg holds the bank-state enum, the default parameter constants, and a log2 helper for counter widths.
REQ-040 One sub-module, ofm_bank_ram, holds storage: a simple dual-port block RAM, one write port and one registered read port.
REQ-041 ofm_tile_buf instantiates ofm_bank_ram once per bank or lane group, as needed to serve WR_LANES writes and RD_LANES reads per cycle.

Verification
REQ-042 Reset sequence: defaults, rst high 2 cycles -> wr_ready=1, rd_valid=0, tile_done=0 on the first cycle after release.
REQ-043 Single tile: write 384 beats with pixel value = (row*48+col)&0xFF.
REQ-044 Single-tile response: tile_done on beat 384; reads give 480 beats, the first beat = {00,01,02,03}, rd_last on beat 480.
REQ-045 Ping-pong: write tiles A and B back-to-back with rd_ready=0 -> wr_ready drops after tile B's last beat.
REQ-046 Ping-pong release: raise rd_ready -> tile A is read fully before tile B, and wr_ready returns after tile A's rd_last.
REQ-047 Backpressure: toggle rd_ready randomly at 50% -> rd_data is stable while stalled and the read sequence is identical to the unstalled run.
REQ-048 Mid-tile clear: assert clear after 100 write beats -> rd_valid stays 0, and a fresh full tile then reads back correctly from bank 0.
